// File: rtl/hex_display_ctrl_pkg.sv
// hex_display_ctrl_pkg: register map, control bits, segment constants, FSM states and BCD helper
package hex_display_ctrl_pkg;
  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam int CTRL_DEC    = 0;
  localparam int CTRL_LZB    = 1;
  localparam int CTRL_BLINK  = 2;
  localparam int CTRL_EN_LSB = 4;
  localparam logic [9:0] CTRL_RST  = 10'h3F0;
  localparam logic [9:0] CTRL_MASK = 10'h3F7;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [23:0] DEC_MAX  = 24'd999999;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;
  function automatic logic [27:0] bcd_adj(input logic [27:0] a);
    logic [27:0] r;
    for (int k = 0; k < 7; k++)
      r[4*k +: 4] = a[4*k +: 4] >= 4'd5 ? a[4*k +: 4] + 4'd3 : a[4*k +: 4];
    return r;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
module seg7_decode (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // lookup table covering 0-F
  always_comb
    case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      default: seg_o = 7'h0E;
    endcase
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: Avalon-MM slave driving six seven-segment digits from one 24-bit value
module hex_display_ctrl
  import hex_display_ctrl_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] WRAP = CW'(HALF - 1);

  logic [23:0]   value_q;
  logic [9:0]    ctrl_q;
  logic [23:0]   disp_q;
  logic          dash_q, ovf_q;
  state_e        state_q;
  logic [4:0]    sh_cnt_q;
  logic [27:0]   acc_q;
  logic [23:0]   sh_q;
  logic [CW-1:0] blink_cnt_q;
  logic          phase_q;
  logic [6:0]    hex_q [6];
  logic [6:0]    hex_d [6];
  logic [6:0]    dec_seg [6];
  logic          wr_value, wr_ctrl, busy, start, abort_hex;
  logic          unused_wd;

  assign unused_wd = ^writedata[31:24];
  assign wr_value  = chipselect && !write_n && address == ADDR_VALUE;
  assign wr_ctrl   = chipselect && !write_n && address == ADDR_CTRL;
  assign busy      = state_q != S_IDLE;
  assign start     = (wr_value && ctrl_q[CTRL_DEC]) || (wr_ctrl && !ctrl_q[CTRL_DEC] && writedata[CTRL_DEC]);
  assign abort_hex = wr_ctrl && ctrl_q[CTRL_DEC] && !writedata[CTRL_DEC] && busy;

  // zero-wait-state read mux over the current register contents
  always_comb
    readdata = address == ADDR_VALUE  ? {8'h0, value_q}
             : address == ADDR_CTRL   ? {22'h0, ctrl_q}
             : address == ADDR_STATUS ? {30'h0, ovf_q, busy}
             : 32'h0;

  // software-visible VALUE and CTRL registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      value_q <= '0;
      ctrl_q  <= CTRL_RST;
    end else begin
      if (wr_value) value_q <= writedata[23:0];
      if (wr_ctrl) ctrl_q <= writedata[9:0] & CTRL_MASK;
    end

  // conversion FSM plus the display digit register it feeds
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= S_IDLE;
      sh_cnt_q <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      disp_q   <= '0;
      dash_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (abort_hex) begin
      state_q <= S_IDLE;
      disp_q  <= value_q;
      dash_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (start) begin
      state_q <= S_LOAD;
    end else if (wr_value && !ctrl_q[CTRL_DEC]) begin
      disp_q <= writedata[23:0];
      dash_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else
      case (state_q)
        S_LOAD: begin
          acc_q    <= '0;
          sh_q     <= value_q;
          sh_cnt_q <= '0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          {acc_q, sh_q} <= {bcd_adj(acc_q), sh_q} << 1;
          sh_cnt_q      <= sh_cnt_q + 5'd1;
          if (sh_cnt_q == 5'd23) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ovf_q   <= value_q > DEC_MAX;
          dash_q  <= value_q > DEC_MAX;
          if (value_q <= DEC_MAX) disp_q <= acc_q[23:0];
        end
        default: ;
      endcase

  // free-running blink phase; writing CTRL with blink off restarts it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (wr_ctrl && !writedata[CTRL_BLINK]) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == WRAP) begin
      blink_cnt_q <= '0;
      phase_q     <= !phase_q;
    end else
      blink_cnt_q <= blink_cnt_q + CW'(1);

  for (genvar d = 0; d < 6; d++) begin : g_dec
    seg7_decode u_dec (.nib_i(disp_q[4*d +: 4]), .seg_o(dec_seg[d]));
  end

  // per-digit priority: disabled, blink-off phase, dash, leading zero, then the digit
  always_comb
    for (int i = 0; i < 6; i++)
      hex_d[i] = !ctrl_q[CTRL_EN_LSB + i] || (ctrl_q[CTRL_BLINK] && phase_q) ? SEG_BLANK
               : dash_q ? SEG_DASH
               : ctrl_q[CTRL_LZB] && i > 0 && (disp_q >> (4 * i)) == 24'd0 ? SEG_BLANK
               : dec_seg[i];

  // registered segment outputs, blank while in reset
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    else
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
endmodule
